// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and the
// supported operand width range.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_is_legal(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder; the per-bit cell reused by the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell per clock, LSB first, carry held in a flop.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    generate
        if (!width_is_legal(WIDTH)) begin : g_bad_width
            $error("serial_adder: WIDTH out of range");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic             accept;
`ifdef SERIAL_ADDER_OVF_EN
    logic             msb_carry;
`endif

    full_adder u_fa (
        .a     (sa[0]),
        .b     (sb[0]),
        .c     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // A start in DONE is accepted like one in IDLE so results can stream back-to-back.
    assign accept = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            msb_carry <= 1'b0;
            ovf       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                end
                SHIFT: begin
                    sum   <= {fa_sum, sum[WIDTH-1:1]};
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    carry <= fa_carry;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
`ifdef SERIAL_ADDER_OVF_EN
                        msb_carry <= carry;
`endif
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    cout  <= carry;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf   <= msb_carry ^ carry;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // sum is left untouched here so the result stays valid through the done pulse.
            if (accept) begin
                sa    <= a;
                sb    <= b;
                carry <= cin;
                cnt   <= '0;
                busy  <= 1'b1;
                state <= SHIFT;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8; checks ovf too
// when built with SERIAL_ADDER_OVF_EN.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int totalCount = 0;
    int badCount   = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] simulation hung");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCount++;
        if (got !== exp) begin
            badCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a clock edge; returns just after the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc);
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Cycles since the accepting edge until done is seen; -1 on timeout.
    task automatic waitDone(input int k0, output int lat, output int busyCnt);
        lat     = -1;
        busyCnt = busy ? 1 : 0;
        for (int k = k0 + 1; k <= k0 + 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busyCnt++;
        end
    endtask

    task automatic countDones(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
    endtask

    initial begin
        int lat;
        int bc;
        int nd;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #3;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_sum",  32'(sum),  32'd0);
        checkOutput("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("rst_ovf",  32'(ovf),  32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] zero add");
        applyStimulus(8'h00, 8'h00, 1'b0);
        checkOutput("zero_busy_after_start", 32'(busy), 32'd1);
        waitDone(0, lat, bc);
        checkOutput("zero_latency", 32'(lat), 32'd9);
        checkOutput("zero_busy_cycles", 32'(bc), 32'd8);
        checkOutput("zero_sum", 32'(sum), 32'h00);
        checkOutput("zero_cout", 32'(cout), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("zero_done_single", 32'(done), 32'd0);

        $display("[TB] wrap");
        applyStimulus(8'hFF, 8'h01, 1'b0);
        waitDone(0, lat, bc);
        checkOutput("wrap_latency", 32'(lat), 32'd9);
        checkOutput("wrap_sum", 32'(sum), 32'h00);
        checkOutput("wrap_cout", 32'(cout), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("wrap_ovf", 32'(ovf), 32'd0);
`endif

        $display("[TB] signed overflow");
        applyStimulus(8'h7F, 8'h01, 1'b0);
        waitDone(0, lat, bc);
        checkOutput("sovf_sum", 32'(sum), 32'h80);
        checkOutput("sovf_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("sovf_ovf", 32'(ovf), 32'd1);
`endif

        $display("[TB] ignored start");
        applyStimulus(8'h12, 8'h34, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        a     = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(4, lat, bc);
        checkOutput("ign_latency", 32'(lat), 32'd9);
        checkOutput("ign_sum", 32'(sum), 32'h47);
        checkOutput("ign_cout", 32'(cout), 32'd0);
        countDones(14, nd);
        checkOutput("ign_extra_done", 32'(nd), 32'd0);

        $display("[TB] reset mid-op");
        applyStimulus(8'hAA, 8'h55, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rmid_busy", 32'(busy), 32'd0);
        checkOutput("rmid_done", 32'(done), 32'd0);
        checkOutput("rmid_sum",  32'(sum),  32'd0);
        checkOutput("rmid_cout", 32'(cout), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        countDones(12, nd);
        checkOutput("rmid_no_done", 32'(nd), 32'd0);
        applyStimulus(8'h03, 8'h04, 1'b0);
        waitDone(0, lat, bc);
        checkOutput("rmid_next_latency", 32'(lat), 32'd9);
        checkOutput("rmid_next_sum", 32'(sum), 32'h07);
        checkOutput("rmid_next_cout", 32'(cout), 32'd0);

        $display("[TB] back-to-back");
        applyStimulus(8'h10, 8'h20, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("b2b_in_done_state_busy", 32'(busy), 32'd0);
        checkOutput("b2b_in_done_state_done", 32'(done), 32'd0);
        a     = 8'h80;
        b     = 8'h80;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b_first_done", 32'(done), 32'd1);
        checkOutput("b2b_first_sum", 32'(sum), 32'h30);
        checkOutput("b2b_first_cout", 32'(cout), 32'd0);
        checkOutput("b2b_second_busy", 32'(busy), 32'd1);
        waitDone(0, lat, bc);
        checkOutput("b2b_second_latency", 32'(lat), 32'd9);
        checkOutput("b2b_second_sum", 32'(sum), 32'h00);
        checkOutput("b2b_second_cout", 32'(cout), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("b2b_second_ovf", 32'(ovf), 32'd1);
`endif
        @(posedge clk);
        #1;
        checkOutput("b2b_done_single", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
